mem_stage_lsu: RTL and testbench

- Memory-access stage between the EX/MEM pipeline register and MEM_WB.
- Takes the ALU result as the address, issues loads and stores to a data-memory bus with a req/ready handshake, and stalls upstream while a transfer is outstanding.
- Sign- or zero-extends load data and presents registered MEM_* outputs for MEM_WB to capture.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_stage_lsu_if.sv | 21 ++
 rtl/mem_stage_lsu.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// The request side is held stable from the first request cycle until DM_READY.
interface mem_stage_lsu_if;
    logic        DM_REQ;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [3:0]  DM_BE;
    logic        DM_READY;
    logic [31:0] DM_RDATA;

    modport master (
        output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE,
        input  DM_READY, DM_RDATA
    );

    modport slave (
        input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE,
        output DM_READY, DM_RDATA
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: issues loads/stores on the data bus, stalls upstream while
// a transfer is outstanding, and registers results and exceptions for MEM_WB.
//
// state | meaning
// IDLE  | accepting; non-memory ops and misaligned ops retire in one cycle
// BUSY  | request outstanding, waiting for DM_READY or timeout
// DRAIN | flushed while outstanding; finish the bus cycle, discard the result
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_VALID,
    input  logic [31:0] EX_ALU_RES,
    input  logic [31:0] EX_STORE_DATA,
    input  logic        EX_MEM_RD,
    input  logic        EX_MEM_WR,
    input  logic [1:0]  EX_SIZE,
    input  logic        EX_UNSIGNED,
    input  logic        EX_NEXT_PC,
    input  logic        EX_RF_D_SEL,
    input  logic        FLUSH,
    mem_stage_lsu_if.master dm,
    output logic        MEM_STALL,
    output logic        MEM_VALID,
    output logic [31:0] MEM_ALU_RES,
    output logic [31:0] MEM_DM_Q,
    output logic        MEM_NEXT_PC,
    output logic        MEM_RF_D_SEL,
    output logic        MEM_EXC,
    output logic [1:0]  MEM_EXC_CAUSE
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_MISAL = 2'b01;
    localparam logic [1:0] CAUSE_TMO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [1:0]    r_size;
    logic          r_rd;
    logic          r_uns;
    logic          r_npc;
    logic          r_rfsel;

    logic          r_dm_req;
    logic          r_dm_we;
    logic [31:0]   r_dm_addr;
    logic [31:0]   r_dm_wdata;
    logic [3:0]    r_dm_be;

    logic          w_is_mem;
    logic          w_misal;
    logic          w_start;
    logic          w_hit;
    logic          w_busyish;
    logic [1:0]    w_lane;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;

    logic          w_issue;
    logic          w_drop;
    logic          w_valid_nxt;
    logic          w_exc_nxt;
    logic [1:0]    w_cause_nxt;
    logic [31:0]   w_alu_nxt;
    logic [31:0]   w_q_nxt;
    logic          w_npc_nxt;
    logic          w_rfsel_nxt;

    assign w_lane    = EX_ALU_RES[1:0];
    assign w_is_mem  = EX_MEM_RD | EX_MEM_WR;
    assign w_misal   = ((EX_SIZE == 2'b01) && EX_ALU_RES[0]) ||
                       (EX_SIZE[1] && (EX_ALU_RES[1:0] != 2'b00));
    assign w_start   = EX_VALID & w_is_mem & ~w_misal & ~FLUSH;
    assign w_hit     = (r_cnt == CNT_LAST);
    assign w_busyish = (r_state == S_BUSY) || (r_state == S_DRAIN);

    assign MEM_STALL = ((r_state == S_IDLE) & w_start) |
                       (w_busyish & ~dm.DM_READY & ~w_hit);

    assign dm.DM_REQ   = r_dm_req;
    assign dm.DM_WE    = r_dm_we;
    assign dm.DM_ADDR  = r_dm_addr;
    assign dm.DM_WDATA = r_dm_wdata;
    assign dm.DM_BE    = r_dm_be;

    // Loads always enable all four lanes; the lane select happens on return.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        if (EX_MEM_WR) begin
            case (EX_SIZE)
                2'b00: begin
                    w_be    = 4'b0001 << w_lane;
                    w_wdata = {4{EX_STORE_DATA[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << w_lane;
                    w_wdata = {2{EX_STORE_DATA[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = EX_STORE_DATA;
                end
            endcase
        end
    end

    assign w_shifted = dm.DM_RDATA >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_load = r_uns ? {24'h0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = r_uns ? {16'h0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        w_valid_nxt = 1'b0;
        w_exc_nxt   = 1'b0;
        w_cause_nxt = CAUSE_NONE;
        w_alu_nxt   = r_addr;
        w_q_nxt     = 32'h0;
        w_npc_nxt   = r_npc;
        w_rfsel_nxt = r_rfsel;
        case (r_state)
            S_IDLE: begin
                if (EX_VALID && !FLUSH) begin
                    if (!w_is_mem || w_misal) begin
                        w_valid_nxt = 1'b1;
                        w_alu_nxt   = EX_ALU_RES;
                        w_npc_nxt   = EX_NEXT_PC;
                        w_rfsel_nxt = EX_RF_D_SEL;
                        if (w_is_mem) begin
                            w_exc_nxt   = 1'b1;
                            w_cause_nxt = CAUSE_MISAL;
                        end
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (dm.DM_READY) begin
                    w_state_nxt = S_IDLE;
                    w_drop      = 1'b1;
                    if (!FLUSH) begin
                        w_valid_nxt = 1'b1;
                        w_q_nxt     = r_rd ? w_load : 32'h0;
                    end
                end else if (FLUSH) begin
                    // A flush on the last allowed cycle has nothing left to drain.
                    if (w_hit) begin
                        w_state_nxt = S_IDLE;
                        w_drop      = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_hit) begin
                    w_state_nxt = S_IDLE;
                    w_drop      = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_exc_nxt   = 1'b1;
                    w_cause_nxt = CAUSE_TMO;
                end
            end
            S_DRAIN: begin
                if (dm.DM_READY || w_hit) begin
                    w_state_nxt = S_IDLE;
                    w_drop      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (w_busyish && !w_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'h0;
            r_size     <= 2'b00;
            r_rd       <= 1'b0;
            r_uns      <= 1'b0;
            r_npc      <= 1'b0;
            r_rfsel    <= 1'b0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 32'h0;
            r_dm_wdata <= 32'h0;
            r_dm_be    <= 4'h0;
        end else if (w_issue) begin
            r_addr     <= EX_ALU_RES;
            r_size     <= EX_SIZE;
            r_rd       <= EX_MEM_RD;
            r_uns      <= EX_UNSIGNED;
            r_npc      <= EX_NEXT_PC;
            r_rfsel    <= EX_RF_D_SEL;
            r_dm_req   <= 1'b1;
            r_dm_we    <= EX_MEM_WR;
            r_dm_addr  <= {EX_ALU_RES[31:2], 2'b00};
            r_dm_wdata <= w_wdata;
            r_dm_be    <= w_be;
        end else if (w_drop) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
        end
    end

    // Valid/exception are per-cycle pulses; the data fields hold between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_VALID     <= 1'b0;
            MEM_EXC       <= 1'b0;
            MEM_EXC_CAUSE <= CAUSE_NONE;
            MEM_ALU_RES   <= 32'h0;
            MEM_DM_Q      <= 32'h0;
            MEM_NEXT_PC   <= 1'b0;
            MEM_RF_D_SEL  <= 1'b0;
        end else begin
            MEM_VALID     <= w_valid_nxt;
            MEM_EXC       <= w_exc_nxt;
            MEM_EXC_CAUSE <= w_cause_nxt;
            if (w_valid_nxt) begin
                MEM_ALU_RES  <= w_alu_nxt;
                MEM_DM_Q     <= w_q_nxt;
                MEM_NEXT_PC  <= w_npc_nxt;
                MEM_RF_D_SEL <= w_rfsel_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected results into a
// scoreboard queue and a negedge monitor pops/compares on every MEM_VALID.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_VALID;
    logic [31:0] EX_ALU_RES;
    logic [31:0] EX_STORE_DATA;
    logic        EX_MEM_RD;
    logic        EX_MEM_WR;
    logic [1:0]  EX_SIZE;
    logic        EX_UNSIGNED;
    logic        EX_NEXT_PC;
    logic        EX_RF_D_SEL;
    logic        FLUSH;
    logic        MEM_STALL;
    logic        MEM_VALID;
    logic [31:0] MEM_ALU_RES;
    logic [31:0] MEM_DM_Q;
    logic        MEM_NEXT_PC;
    logic        MEM_RF_D_SEL;
    logic        MEM_EXC;
    logic [1:0]  MEM_EXC_CAUSE;

    mem_stage_lsu_if dm_bus ();

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .EX_VALID      (EX_VALID),
        .EX_ALU_RES    (EX_ALU_RES),
        .EX_STORE_DATA (EX_STORE_DATA),
        .EX_MEM_RD     (EX_MEM_RD),
        .EX_MEM_WR     (EX_MEM_WR),
        .EX_SIZE       (EX_SIZE),
        .EX_UNSIGNED   (EX_UNSIGNED),
        .EX_NEXT_PC    (EX_NEXT_PC),
        .EX_RF_D_SEL   (EX_RF_D_SEL),
        .FLUSH         (FLUSH),
        .dm            (dm_bus),
        .MEM_STALL     (MEM_STALL),
        .MEM_VALID     (MEM_VALID),
        .MEM_ALU_RES   (MEM_ALU_RES),
        .MEM_DM_Q      (MEM_DM_Q),
        .MEM_NEXT_PC   (MEM_NEXT_PC),
        .MEM_RF_D_SEL  (MEM_RF_D_SEL),
        .MEM_EXC       (MEM_EXC),
        .MEM_EXC_CAUSE (MEM_EXC_CAUSE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] q;
        logic        exc;
        logic [1:0]  cause;
        logic        npc;
        logic        rfsel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [31:0] q, input logic exc,
                            input logic [1:0] cause, input logic npc, input logic rfsel);
        exp_t e;
        e.alu = alu; e.q = q; e.exc = exc; e.cause = cause; e.npc = npc; e.rfsel = rfsel;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (MEM_VALID) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got MEM_VALID=1 alu=%h required no result", MEM_ALU_RES);
                end else begin
                    mon_e = sb.pop_front();
                    chk("mem_alu_res", MEM_ALU_RES, mon_e.alu);
                    chk("mem_dm_q", MEM_DM_Q, mon_e.q);
                    chk("mem_exc", {31'h0, MEM_EXC}, {31'h0, mon_e.exc});
                    chk("mem_exc_cause", {30'h0, MEM_EXC_CAUSE}, {30'h0, mon_e.cause});
                    chk("mem_next_pc", {31'h0, MEM_NEXT_PC}, {31'h0, mon_e.npc});
                    chk("mem_rf_d_sel", {31'h0, MEM_RF_D_SEL}, {31'h0, mon_e.rfsel});
                end
            end else if (MEM_EXC) begin
                checks++;
                errors++;
                $display("FAIL exc_without_valid: got MEM_EXC=1 required 0");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EX_VALID = 1'b0; EX_MEM_RD = 1'b0; EX_MEM_WR = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic set_ex(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, input logic [1:0] sz, input logic uns,
                          input logic npc, input logic rfsel);
        EX_VALID = 1'b1; EX_ALU_RES = a; EX_STORE_DATA = d; EX_MEM_RD = rd;
        EX_MEM_WR = wr; EX_SIZE = sz; EX_UNSIGNED = uns; EX_NEXT_PC = npc;
        EX_RF_D_SEL = rfsel; FLUSH = 1'b0;
    endtask

    // rdy = BUSY cycle carrying DM_READY (0: never). Expected stall/request cycles = e_cyc.
    task automatic run_mem(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input int rdy, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wd, input int e_cyc);
        int stall_n = 0;
        int req_n = 0;
        logic bad = 1'b0;
        logic done = 1'b0;
        logic [68:0] snap = '0;
        logic [68:0] cur;
        step();
        set_ex(a, d, rd, wr, sz, uns, 1'b1, 1'b0);
        dm_bus.DM_RDATA = rdata;
        for (int c = 0; c < 40 && !done; c++) begin
            dm_bus.DM_READY = (rdy > 0) && (c == rdy);
            @(negedge clk);
            if (MEM_STALL) stall_n++;
            if (dm_bus.DM_REQ) req_n++;
            cur = {dm_bus.DM_WE, dm_bus.DM_ADDR, dm_bus.DM_BE, dm_bus.DM_WDATA};
            if (c == 1) begin
                snap = cur;
                chk({nm, "_we"}, {31'h0, dm_bus.DM_WE}, {31'h0, wr});
                chk({nm, "_addr"}, dm_bus.DM_ADDR, e_addr);
                chk({nm, "_be"}, {28'h0, dm_bus.DM_BE}, {28'h0, e_be});
                chk({nm, "_wdata"}, dm_bus.DM_WDATA, e_wd);
            end else if (c > 1 && cur !== snap) begin
                bad = 1'b1;
            end
            if (!MEM_STALL) done = 1'b1;
            else step();
        end
        chk({nm, "_finished"}, {31'h0, done}, 32'h1);
        chk({nm, "_stall_cycles"}, stall_n, e_cyc);
        chk({nm, "_req_cycles"}, req_n, e_cyc);
        chk({nm, "_bus_unstable"}, {31'h0, bad}, 32'h0);
        step();
        idle_inputs();
        dm_bus.DM_READY = 1'b0;
        @(negedge clk);
        chk({nm, "_req_drop"}, {31'h0, dm_bus.DM_REQ}, 32'h0);
    endtask

    task automatic run_plain(input string nm, input logic [31:0] a);
        step();
        push_exp(a, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1);
        set_ex(a, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk({nm, "_stall"}, {31'h0, MEM_STALL}, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic run_misal(input string nm, input logic [31:0] a, input logic rd,
                             input logic wr, input logic [1:0] sz);
        step();
        push_exp(a, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0);
        set_ex(a, 32'h55AA_00FF, rd, wr, sz, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk({nm, "_stall"}, {31'h0, MEM_STALL}, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        chk({nm, "_no_req"}, {31'h0, dm_bus.DM_REQ}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        EX_ALU_RES = 32'h0; EX_STORE_DATA = 32'h0; EX_SIZE = 2'b00;
        EX_UNSIGNED = 1'b0; EX_NEXT_PC = 1'b0; EX_RF_D_SEL = 1'b0;
        dm_bus.DM_READY = 1'b0;
        dm_bus.DM_RDATA = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, dm_bus.DM_REQ}, 32'h0);
        chk("rst_valid", {31'h0, MEM_VALID}, 32'h0);
        chk("rst_exc", {31'h0, MEM_EXC}, 32'h0);
        chk("rst_alu", MEM_ALU_RES, 32'h0);
        chk("rst_stall", {31'h0, MEM_STALL}, 32'h0);
        rst_n = 1'b1;

        run_plain("plain", 32'h0000_1234);

        push_exp(32'h103, 32'hFFFF_FF80, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("ldb_s", 32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 3, 32'h80FF_FFFF,
                32'h100, 4'b1111, 32'h0, 3);
        push_exp(32'h103, 32'h0000_0080, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("ldb_u", 32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 3, 32'h80FF_FFFF,
                32'h100, 4'b1111, 32'h0, 3);
        push_exp(32'h41, 32'h0000_007F, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("ldb_l1", 32'h41, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1, 32'h0000_7F00,
                32'h40, 4'b1111, 32'h0, 1);
        push_exp(32'h22, 32'hFFFF_8001, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("ldh_s", 32'h22, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1, 32'h8001_1234,
                32'h20, 4'b1111, 32'h0, 1);
        push_exp(32'h20, 32'h0000_F234, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("ldh_u", 32'h20, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 2, 32'h8001_F234,
                32'h20, 4'b1111, 32'h0, 2);
        push_exp(32'h300, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("ldw", 32'h300, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1, 32'hDEAD_BEEF,
                32'h300, 4'b1111, 32'h0, 1);

        push_exp(32'h202, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("sth", 32'h202, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 3, 32'h0,
                32'h200, 4'b1100, 32'hBEEF_BEEF, 3);
        push_exp(32'h1, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("stb", 32'h1, 32'h1234_565A, 1'b0, 1'b1, 2'b00, 1'b0, 1, 32'h0,
                32'h0, 4'b0010, 32'h5A5A_5A5A, 1);
        push_exp(32'h10, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        run_mem("stw", 32'h10, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b11, 1'b0, 2, 32'h0,
                32'h10, 4'b1111, 32'hCAFE_F00D, 2);

        run_misal("misal_w", 32'h301, 1'b1, 1'b0, 2'b10);
        run_misal("misal_h", 32'h105, 1'b0, 1'b1, 2'b01);

        push_exp(32'h500, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0);
        run_mem("tmo", 32'h500, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 0, 32'h0,
                32'h500, 4'b1111, 32'h0, 16);

        // Flush in the second BUSY cycle, ready two cycles later.
        step();
        set_ex(32'h600, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_accept_stall", {31'h0, MEM_STALL}, 32'h1);
        step();
        @(negedge clk);
        chk("fl_busy1_req", {31'h0, dm_bus.DM_REQ}, 32'h1);
        step();
        FLUSH = 1'b1;
        @(negedge clk);
        chk("fl_busy2_stall", {31'h0, MEM_STALL}, 32'h1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("fl_drain_req", {31'h0, dm_bus.DM_REQ}, 32'h1);
        chk("fl_drain_stall", {31'h0, MEM_STALL}, 32'h1);
        step();
        dm_bus.DM_READY = 1'b1;
        @(negedge clk);
        chk("fl_drain_done_stall", {31'h0, MEM_STALL}, 32'h0);
        step();
        dm_bus.DM_READY = 1'b0;
        @(negedge clk);
        chk("fl_req_drop", {31'h0, dm_bus.DM_REQ}, 32'h0);
        run_plain("fl_after", 32'h0000_0ABC);

        // Flush together with ready: transfer completes, result discarded.
        step();
        set_ex(32'h700, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        step();
        FLUSH = 1'b1;
        dm_bus.DM_READY = 1'b1;
        @(negedge clk);
        chk("flr_stall", {31'h0, MEM_STALL}, 32'h0);
        step();
        idle_inputs();
        dm_bus.DM_READY = 1'b0;
        @(negedge clk);
        chk("flr_req_drop", {31'h0, dm_bus.DM_REQ}, 32'h0);

        // Flush on an accepting memory op never reaches the bus.
        step();
        set_ex(32'h710, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        FLUSH = 1'b1;
        @(negedge clk);
        chk("fli_stall", {31'h0, MEM_STALL}, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("fli_no_req", {31'h0, dm_bus.DM_REQ}, 32'h0);

        // Reset in the middle of BUSY.
        step();
        set_ex(32'h804, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("mrst_req", {31'h0, dm_bus.DM_REQ}, 32'h0);
        chk("mrst_we", {31'h0, dm_bus.DM_WE}, 32'h0);
        chk("mrst_addr", dm_bus.DM_ADDR, 32'h0);
        chk("mrst_be", {28'h0, dm_bus.DM_BE}, 32'h0);
        chk("mrst_valid", {31'h0, MEM_VALID}, 32'h0);
        chk("mrst_alu", MEM_ALU_RES, 32'h0);
        chk("mrst_stall", {31'h0, MEM_STALL}, 32'h0);
        step();
        rst_n = 1'b1;
        run_plain("post_rst", 32'h0000_5678);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
